// File: rtl/alu_dispatch_if.sv
// Instruction handshake bundle between an instruction source and the dispatch stage.
// The source owns valid and the instruction word; the stage owns ready.
interface alu_dispatch_if;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic [31:0] instr_in;

    modport master (
        output instr_valid_in,
        output instr_in,
        input  instr_ready_out
    );

    modport slave (
        input  instr_valid_in,
        input  instr_in,
        output instr_ready_out
    );
endinterface

// File: rtl/alu_dispatch.sv
// Dispatch/writeback stage wrapped around a combinational ALU: issues operands from an
// 8-entry register file, retires the ALU result one cycle later, bypasses back-to-back hazards.
module alu_dispatch #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    alu_dispatch_if.slave         instrBus,
    output logic                  alu_enable_out,
    output logic [7:0]            alu_opcode_out,
    output logic [DATA_WIDTH-1:0] alu_input1_out,
    output logic [DATA_WIDTH-1:0] alu_input2_out,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [4:0]            alu_flags_in,
    output logic [4:0]            flags_out,
    output logic                  retire_out,
    output logic                  illegal_out,
    input  logic [2:0]            dbg_addr_in,
    output logic [DATA_WIDTH-1:0] dbg_data_out
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0]   input1_q, input1_d;
    logic [DATA_WIDTH-1:0]   input2_q, input2_d;
    logic [2:0]              rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   regFile_q [REG_COUNT];
    logic [4:0]              flags_q;
    logic                    retire_q;
    logic                    illegal_q;

    logic [7:0]              opField;
    logic [2:0]              rdField, rs1Field, rs2Field;
    logic [7:0]              immField;
    logic                    accept;
    logic                    isLegal;
    logic                    illegalSet;
    logic [DATA_WIDTH-1:0]   rs1Val, rs2Val;
    logic                    unusedInstrBits;

    assign opField         = instrBus.instr_in[31:24];
    assign rdField         = instrBus.instr_in[22:20];
    assign rs1Field        = instrBus.instr_in[18:16];
    assign rs2Field        = instrBus.instr_in[14:12];
    assign immField        = instrBus.instr_in[7:0];
    assign unusedInstrBits = ^{instrBus.instr_in[23], instrBus.instr_in[19],
                               instrBus.instr_in[15], instrBus.instr_in[11:8]};

    assign instrBus.instr_ready_out = !reset_in;
    assign accept = instrBus.instr_valid_in && !reset_in;

    always_comb begin
        isLegal = 1'b0;
        case (opField)
            8'h00, 8'h01, 8'h03, 8'h04, 8'h09, 8'h0A, 8'h0B: isLegal = 1'b1;
            default:                                         isLegal = 1'b0;
        endcase
    end

    // The instruction in EXEC writes its rd at this very edge, so a dependent read
    // takes the live ALU result rather than the not-yet-updated register file.
    always_comb begin
        rs1Val = '0;
        rs2Val = '0;
        if (rs1Field != 3'd0) begin
            if (state_q == EXEC && rd_q != 3'd0 && rd_q == rs1Field)
                rs1Val = alu_result_in;
            else
                rs1Val = regFile_q[rs1Field];
        end
        if (rs2Field != 3'd0) begin
            if (state_q == EXEC && rd_q != 3'd0 && rd_q == rs2Field)
                rs2Val = alu_result_in;
            else
                rs2Val = regFile_q[rs2Field];
        end
    end

    always_comb begin
        state_d    = IDLE;
        opcode_d   = '0;
        input1_d   = '0;
        input2_d   = '0;
        rd_d       = '0;
        illegalSet = 1'b0;
        if (accept) begin
            if (isLegal) begin
                state_d  = EXEC;
                opcode_d = opField;
                rd_d     = rdField;
                input1_d = rs1Val;
                case (opField)
                    8'h09, 8'h0A: input2_d = DATA_WIDTH'(immField);
                    8'h0B:        input2_d = '0;
                    default:      input2_d = rs2Val;
                endcase
            end else begin
                illegalSet = 1'b1;
            end
        end
    end

    // Execute slot is cleared whenever nothing legal is accepted, so IDLE drives zeros.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            input1_q  <= '0;
            input2_q  <= '0;
            rd_q      <= '0;
            flags_q   <= '0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regFile_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            input1_q <= input1_d;
            input2_q <= input2_d;
            rd_q     <= rd_d;
            retire_q <= (state_q == EXEC);
            if (state_q == EXEC) begin
                flags_q <= alu_flags_in;
                if (rd_q != 3'd0) begin
                    regFile_q[rd_q] <= alu_result_in;
                end
            end
            if (illegalSet) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign alu_enable_out = (state_q == EXEC);
    assign alu_opcode_out = opcode_q;
    assign alu_input1_out = input1_q;
    assign alu_input2_out = input2_q;
    assign flags_out      = flags_q;
    assign retire_out     = retire_q;
    assign illegal_out    = illegal_q;
    assign dbg_data_out   = (dbg_addr_in == 3'd0) ? '0 : regFile_q[dbg_addr_in];

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Instruction dispatch and writeback stage placed directly around the combinational ALU. It accepts 32-bit instruction words over a valid/ready handshake and reads operands from an 8-entry register file. It drives the ALU's opcode, operand and enable inputs from registered outputs. One cycle later it captures the ALU result and flags, writes the result back to the destination register, and updates an architectural flag register, with result bypass for back-to-back dependencies.

## Interface
Parameters:
- DATA_WIDTH, 8: operand and register width; the ALU bus width.
- REG_COUNT, 8: register file depth. Register addresses are 3 bits wide.

Ports, clock and reset first:
- clock_in, input, 1: single clock; all state updates on the rising edge.
- reset_in, input, 1: reset, asynchronous and active-high.
- instr_valid_in, input, 1: instr_in holds an instruction.
- instr_ready_out, output, 1: stage can accept an instruction.
- instr_in, input, 32: instruction word. Fields: [31:24] opcode, [22:20] rd, [18:16] rs1, [14:12] rs2, [7:0] imm. All other bits are ignored.
- alu_enable_out, output, 1: drives the ALU enable_in.
- alu_opcode_out, output, 8: drives the ALU opcode_in.
- alu_input1_out, output, DATA_WIDTH: drives alu_input1.
- alu_input2_out, output, DATA_WIDTH: drives alu_input2.
- alu_result_in, input, DATA_WIDTH: ALU alu_output. Combinational from the *_out signals above.
- alu_flags_in, input, 5: ALU flags packed as {overflow, carry, zero, sign, parity}.
- flags_out, output, 5: architectural flag register, same packing as alu_flags_in.
- retire_out, output, 1: one-cycle pulse when an instruction writes back.
- illegal_out, output, 1: sticky flag; set when an illegal opcode is accepted.
- dbg_addr_in, input, 3: debug register read address.
- dbg_data_out, output, DATA_WIDTH: combinational read of the register at dbg_addr_in. Reads the stored value, not the bypassed value.

## Operation
- Legal opcodes:
  - ADD 0x00: operands rs1, rs2.
  - SUBTRACT 0x01: operands rs1, rs2.
  - EQUALS 0x03: operands rs1, rs2.
  - GREATER_THAN 0x04: operands rs1, rs2.
  - ADD_IMMEDIATE 0x09: operands rs1, imm.
  - SUBTRACT_IMMEDIATE 0x0A: operands rs1, imm.
  - MOV 0x0B: input1 = rs1, input2 = 0.
- All other opcodes are illegal, including MULTIPLY 0x02.
- Register r0 always reads 0. Writes to r0 are discarded. Flags still update on a write targeting r0.
- The stage has two states, tracked by an internal execute-valid bit:
  - IDLE: no instruction in the execute slot.
  - EXEC: the execute slot holds an accepted legal instruction.
- Accepting an instruction (handshake true at an edge):
  - Legal opcode: load alu_opcode_out, operands and rd into the execute slot, and enter EXEC.
  - Illegal opcode: set illegal_out and go to or stay in IDLE. No register write and no flag change.
- Leaving EXEC: at the next edge, write alu_result_in to rd, load flags_out from alu_flags_in, and pulse retire_out. The state then becomes EXEC again if a new legal instruction is accepted on the same edge, otherwise IDLE.
- Bypass: when an instruction is accepted while EXEC holds a write to rd ≠ 0, any of its rs1/rs2 reads equal to that rd take alu_result_in instead of the register file value.
- alu_enable_out is 1 exactly in EXEC. In IDLE, alu_opcode_out and both operand outputs are 0.
- instr_ready_out = !reset_in. The stage never stalls, so a throughput of one instruction per cycle is sustained.

## Timing
- Reset (asynchronous, in effect while asserted):
  - All registers and flags_out = 0.
  - illegal_out = 0, retire_out = 0.
  - alu_enable_out = 0, alu_opcode_out = 0, alu_input1_out = 0, alu_input2_out = 0.
  - State = IDLE; instr_ready_out = 0.
- Reset asserted with an instruction in EXEC: that instruction is discarded with no writeback.
- Instruction accepted at edge N:
  - ALU is driven during cycle N+1.
  - rd and flags_out are updated at edge N+1.
  - retire_out is high during cycle N+1 → N+2.
  - The written value is visible on dbg_data_out after edge N+1.
- Back-to-back dependent instructions need no bubble; the bypass removes the hazard.
- illegal_out stays 1 until reset.

## Test plan
- Reset then ADDI r1,r0,#5 → alu_input1_out=0, alu_input2_out=5, alu_enable_out=1 one cycle after accept. r1=0x05 and retire_out pulses at the following edge; flags_out zero bit = 0.
- ADDI r1,r0,#0x7F, then back-to-back ADDI r2,r1,#1 → second issue gets alu_input1_out=0x7F via bypass. r2=0x80 and flags_out = {overflow=1, carry=0, zero=0, sign=1, parity=1}.
- SUB r3,r1,r1 with r1=0x7F → r3=0x00, zero bit set. Then EQ r4,r1,r1 → r4=0x01. Then GT r5,r0,r1 → r5=0x00.
- Opcode 0x02 accepted → illegal_out rises and stays 1. retire_out stays 0 and alu_enable_out stays 0. The next legal instruction executes normally.
- ADDI r0,r0,#9 → dbg_addr_in=0 still reads 0x00 and retire_out pulses. MOV r6,r0 → r6=0x00.
- Assert reset_in asynchronously mid-cycle while in EXEC → all outputs 0 immediately and the pending rd write is not performed. After release, instr_ready_out=1 on the next cycle.
